spi_word_receiver: RTL and testbench
====================================

Name: spi_word_receiver

Overview:
- Parametrised, framed SPI receive front-end for the HUB75 controller. Successor to the fixed 32-bit, unframed receiver.
- Deserialises MOSI into WORD_WIDTH-bit words, framed by an active-low chip select. Buffers completed words in a small FIFO with a valid/ready pop interface and reports overflow and dropped partial words.
- Sits between the host SPI pins and the pixel/row loader. Everything runs in the spi_clk domain.

Parameters:
- WORD_WIDTH, 32, bits per word; even, >= 8.
- FIFO_DEPTH, 4, words of buffering; power of two, >= 2.
- MSB_FIRST, 1, 1 = first bit on the wire lands in bit WORD_WIDTH-1; 0 = first bit lands in bit 0.

Ports:
- spi_clk  in  1  SPI clock; all state updates on rising edge.
- reset  in  1  Synchronous, active-high.
- spi_cs_n  in  1  Active-low frame select, sampled on spi_clk rising edge.
- spi_mosi  in  1  Serial data, sampled on spi_clk rising edge.
- word_data  out  WORD_WIDTH  Head-of-FIFO word (show-ahead).
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  Consumer pop request; a pop occurs when word_valid && word_ready.
- fill_level  out  clog2(FIFO_DEPTH)+1  Number of words held.
- overflow  out  1  Sticky: a completed word was dropped because the FIFO was full.
- partial_drop  out  1  One-cycle pulse: a frame ended mid-word.
- pixel_clock  out  1  High while bit_count < WORD_WIDTH/2; low in the second half of a word.

Behaviour:
- Reset values:
  - bit_count = 0, shift register = 0, FIFO empty.
  - word_data = 0, word_valid = 0, fill_level = 0, overflow = 0, partial_drop = 0, pixel_clock = 1.
  - Reset wins over all other activity, including mid-word and mid-frame.
- Framing:
  - While spi_cs_n = 1, no bit is sampled and bit_count is held at 0.
  - If bit_count != 0 on an edge where spi_cs_n = 1, the partial word is discarded and partial_drop is pulsed high for that edge's cycle.
- Shifting:
  - On each edge with spi_cs_n = 0, spi_mosi is stored at position (MSB_FIRST ? WORD_WIDTH-1-bit_count : bit_count).
  - bit_count increments modulo WORD_WIDTH.
- Word completion:
  - On the edge that samples bit index WORD_WIDTH-1, the assembled word (including that bit) is pushed and bit_count wraps to 0.
  - Push latency: word_valid rises after that same edge if the FIFO was empty, i.e. 1 spi_clk edge after the last bit.
  - Back-to-back words within one frame need no idle bits.
- FIFO:
  - Circular buffer with separate read/write pointers and a fill counter.
  - word_data is registered show-ahead, equal to mem[rd_ptr]; it is 0 when empty.
  - Pointers wrap at FIFO_DEPTH.
- Full:
  - A push with fill_level == FIFO_DEPTH and no pop on the same edge is dropped; overflow is set.
  - Push plus pop on the same edge while full both succeed; fill_level is unchanged.
- Empty: word_ready with word_valid = 0 has no effect, and no underflow is possible.
- Push plus pop on the same edge while fill_level == 1: the popped word leaves, the new word becomes head, word_valid stays 1.
- overflow clears only on reset.
- Clock caveat: spi_clk may stop between frames. The consumer must be clocked by spi_clk, and draining only progresses while the host clocks. The host sends idle clocks with spi_cs_n = 1 to flush.

Decomposition:
- Shared package hub75_spi_pkg:
  - Constants for the default WORD_WIDTH (32) and FIFO_DEPTH (4).
  - A clog2 function.
  - Pixel word field offsets (RGB upper/lower), reused by the loader.
- One sub-module, spi_word_fifo:
  - Parametrised WIDTH/DEPTH synchronous FIFO.
  - Provides push, pop, show-ahead head, fill count and full/empty.
  - The top keeps the shift register, bit counter, framing and flag logic.

Test Plan:
- Defaults, MSB_FIRST = 1, CS low, shift 0xDEADBEEF MSB first -> word_valid rises after edge 32, word_data = 0xDEADBEEF, fill_level = 1; pixel_clock low for bit_count 16..31.
- Three words 0x00000001, 0x80000000, 0xA5A5A5A5 back-to-back in one frame, word_ready = 1 -> popped in order, no gaps, fill_level never exceeds 1.
- word_ready = 0, 5 words sent (FIFO_DEPTH = 4) -> fill_level = 4, overflow = 1 after edge 160; first 4 words intact, 5th lost. Then same-edge push/pop while full with a 6th word -> fill_level stays 4.
- CS low for 12 bits, then CS high -> partial_drop pulse one cycle, no push, bit_count = 0. Next full word 0x12345678 received correctly.
- WORD_WIDTH = 16, MSB_FIRST = 0, bits 1,0,0,0,... (LSB first) -> word_data = 0x0001.
- Reset asserted after 20 bits with FIFO holding 2 words -> all outputs at reset values next edge, overflow cleared. A subsequent word is received cleanly.

Source files
------------

// File: rtl/hub75_spi_pkg.sv
// Shared definitions for the HUB75 SPI receive path and the pixel/row loader.
// Holds the default word and FIFO sizes, a clog2 helper, and pixel word field offsets.
// No ports; import with hub75_spi_pkg::*.
package hub75_spi_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Pixel word layout used by the loader. Each 3-bit group is R,G,B for the
  // upper half of the panel (first scan line of a pair) and the lower half.
  localparam int PIX_R_UPPER = 0;
  localparam int PIX_G_UPPER = 1;
  localparam int PIX_B_UPPER = 2;
  localparam int PIX_R_LOWER = 3;
  localparam int PIX_G_LOWER = 4;
  localparam int PIX_B_LOWER = 5;
  localparam int PIX_FIELD_BITS = 6;

  // Ceiling log2. clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Synchronous circular-buffer FIFO with a registered show-ahead head word.
// Ports: spi_clk/reset; push/push_data in; pop in (ignored while empty);
// head_data (0 when empty), count, full, empty out. A push while full only
// succeeds if a pop happens on the same edge.
import hub75_spi_pkg::*;

module spi_word_fifo #(
  parameter int WIDTH = DEFAULT_WORD_WIDTH,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                    spi_clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when a slot frees on the same edge.
  assign push_ok = push && (!full || pop_ok);

  // Pointers are exactly AW bits wide, so they wrap at DEPTH on their own.
  assign rd_ptr_next = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // The head register shows what mem[rd_ptr] will hold after this edge. The
  // only case where that slot is the one being written right now is when the
  // FIFO will hold exactly the word being pushed, so forward it.
  always_comb begin
    head_next = '0;
    if (count_next != '0) begin
      if (push_ok && (rd_ptr_next == wr_ptr)) begin
        head_next = push_data;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge spi_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
    end else begin
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      head_data <= head_next;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_word_receiver.sv
// Framed SPI receive front-end: deserialises MOSI into WORD_WIDTH-bit words
// while spi_cs_n is low and queues them in a show-ahead FIFO.
// Ports: spi_clk/reset; spi_cs_n/spi_mosi from the host; word_data/word_valid/
// word_ready pop interface; fill_level, sticky overflow, partial_drop pulse and
// pixel_clock (high during the first half of each word) status outputs.
import hub75_spi_pkg::*;

module spi_word_receiver #(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int MSB_FIRST  = 1
) (
  input  logic                       spi_clk,
  input  logic                       reset,
  input  logic                       spi_cs_n,
  input  logic                       spi_mosi,
  output logic [WORD_WIDTH-1:0]      word_data,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [clog2(FIFO_DEPTH):0] fill_level,
  output logic                       overflow,
  output logic                       partial_drop,
  output logic                       pixel_clock
);

  localparam int BW = (clog2(WORD_WIDTH) < 1) ? 1 : clog2(WORD_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);
  localparam logic [BW-1:0] HALF_BIT = BW'(WORD_WIDTH / 2);

  logic [BW-1:0]         bit_count;
  logic [BW-1:0]         bit_count_next;
  logic [BW-1:0]         bit_pos;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [WORD_WIDTH-1:0] shift_next;
  logic [WORD_WIDTH-1:0] word_assembled;
  logic                  word_push;
  logic                  drop_next;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign bit_pos = (MSB_FIRST != 0) ? (LAST_BIT - bit_count) : bit_count;

  always_comb begin
    word_assembled = shift_reg;
    shift_next     = shift_reg;
    bit_count_next = bit_count;
    word_push      = 1'b0;
    drop_next      = 1'b0;
    if (spi_cs_n) begin
      // Frame closed: anything half-assembled is thrown away.
      bit_count_next = '0;
      shift_next     = '0;
      drop_next      = (bit_count != '0);
    end else begin
      word_assembled[bit_pos] = spi_mosi;
      if (bit_count == LAST_BIT) begin
        // The word pushed includes the bit sampled on this very edge.
        word_push      = 1'b1;
        bit_count_next = '0;
        shift_next     = '0;
      end else begin
        bit_count_next = bit_count + BW'(1);
        shift_next     = word_assembled;
      end
    end
  end

  assign pop         = word_valid && word_ready;
  assign word_valid  = !fifo_empty;
  assign pixel_clock = (bit_count < HALF_BIT);

  always_ff @(posedge spi_clk) begin
    if (reset) begin
      bit_count    <= '0;
      shift_reg    <= '0;
      partial_drop <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      bit_count    <= bit_count_next;
      shift_reg    <= shift_next;
      partial_drop <= drop_next;
      // The FIFO silently refuses this push; remember it until reset.
      if (word_push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  spi_word_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .spi_clk   (spi_clk),
    .reset     (reset),
    .push      (word_push),
    .push_data (word_assembled),
    .pop       (pop),
    .head_data (word_data),
    .count     (fill_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_spi_word_receiver.sv
// Directed bench for spi_word_receiver: a default instance (32-bit, MSB first,
// depth 4) and a 16-bit LSB-first instance share clock and reset.
// Inputs change 1 time unit after each rising edge; outputs are read there too.
module tb_spi_word_receiver;

  logic        spi_clk = 1'b0;
  logic        reset;
  logic        spi_cs_n, spi_mosi, word_ready;
  logic [31:0] word_data;
  logic        word_valid;
  logic [2:0]  fill_level;
  logic        overflow, partial_drop, pixel_clock;

  logic        cs16_n, mosi16, ready16;
  logic [15:0] data16;
  logic        valid16;
  logic [2:0]  fill16;
  logic        ovf16, pdrop16, pclk16;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 spi_clk = ~spi_clk;

  spi_word_receiver dut (
    .spi_clk(spi_clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .fill_level(fill_level), .overflow(overflow), .partial_drop(partial_drop),
    .pixel_clock(pixel_clock)
  );

  spi_word_receiver #(.WORD_WIDTH(16), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut16 (
    .spi_clk(spi_clk), .reset(reset), .spi_cs_n(cs16_n), .spi_mosi(mosi16),
    .word_data(data16), .word_valid(valid16), .word_ready(ready16),
    .fill_level(fill16), .overflow(ovf16), .partial_drop(pdrop16),
    .pixel_clock(pclk16)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge spi_clk);
    #1;
  endtask

  task automatic clk_bit(input logic cs_n, input logic b);
    spi_cs_n = cs_n;
    spi_mosi = b;
    step();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) clk_bit(1'b0, w[i]);
  endtask

  logic [31:0] vec;
  logic [31:0] tri_words [3];
  logic [31:0] ovf_words [6];
  logic [15:0] v16;
  int          max_fill;

  initial begin
    reset = 1'b1; spi_cs_n = 1'b1; spi_mosi = 1'b0; word_ready = 1'b0;
    cs16_n = 1'b1; mosi16 = 1'b0; ready16 = 1'b0;
    step(); step();

    // ---- reset values ----
    check_val("rst_valid", word_valid, 0);
    check_val("rst_data", word_data, 0);
    check_val("rst_fill", fill_level, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_pdrop", partial_drop, 0);
    check_val("rst_pclk", pixel_clock, 1);
    check_val("rst16_valid", valid16, 0);
    check_val("rst16_pclk", pclk16, 1);
    reset = 1'b0;
    step();

    // ---- single word 0xDEADBEEF, MSB first ----
    vec = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) begin
      clk_bit(1'b0, vec[31-i]);
      if (i == 14) check_val("pclk_bc15", pixel_clock, 1);
      if (i == 15) check_val("pclk_bc16", pixel_clock, 0);
      if (i == 30) begin
        check_val("pclk_bc31", pixel_clock, 0);
        check_val("valid_edge31", word_valid, 0);
      end
    end
    check_val("w1_valid", word_valid, 1);
    check_val("w1_data", word_data, 32'hDEADBEEF);
    check_val("w1_fill", fill_level, 1);
    check_val("w1_pclk", pixel_clock, 1);
    check_val("w1_pdrop", partial_drop, 0);
    word_ready = 1'b1;
    clk_bit(1'b1, 1'b0);
    check_val("w1_pop_valid", word_valid, 0);
    check_val("w1_pop_data", word_data, 0);
    check_val("w1_pop_fill", fill_level, 0);

    // ---- three back-to-back words with consumer always ready ----
    tri_words[0] = 32'h00000001; tri_words[1] = 32'h80000000; tri_words[2] = 32'hA5A5A5A5;
    max_fill = 0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 31; i >= 0; i--) begin
        clk_bit(1'b0, tri_words[w][i]);
        if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
      end
      check_val($sformatf("b2b_data%0d", w), word_data, tri_words[w]);
      check_val($sformatf("b2b_valid%0d", w), word_valid, 1);
    end
    check_val("b2b_maxfill", max_fill, 1);
    clk_bit(1'b1, 1'b0);
    check_val("b2b_drained", word_valid, 0);

    // ---- overflow: five words into depth 4, then push+pop while full ----
    word_ready = 1'b0;
    ovf_words[0] = 32'hC0DE0000; ovf_words[1] = 32'hC0DE0001; ovf_words[2] = 32'hC0DE0002;
    ovf_words[3] = 32'hC0DE0003; ovf_words[4] = 32'hC0DE0004; ovf_words[5] = 32'hC0DE0005;
    for (int w = 0; w < 4; w++) send_word(ovf_words[w]);
    check_val("ovf_fill4", fill_level, 4);
    check_val("ovf_not_yet", overflow, 0);
    send_word(ovf_words[4]);
    check_val("ovf_fill_after5", fill_level, 4);
    check_val("ovf_set", overflow, 1);
    check_val("ovf_head", word_data, 32'hC0DE0000);
    for (int i = 31; i >= 1; i--) clk_bit(1'b0, ovf_words[5][i]);
    word_ready = 1'b1;
    clk_bit(1'b0, ovf_words[5][0]);
    check_val("full_pushpop_fill", fill_level, 4);
    check_val("full_pushpop_head", word_data, 32'hC0DE0001);
    check_val("ovf_sticky", overflow, 1);
    clk_bit(1'b1, 1'b0);
    check_val("drain_1", word_data, 32'hC0DE0002);
    clk_bit(1'b1, 1'b0);
    check_val("drain_2", word_data, 32'hC0DE0003);
    clk_bit(1'b1, 1'b0);
    check_val("drain_3", word_data, 32'hC0DE0005);
    check_val("drain_3_fill", fill_level, 1);
    clk_bit(1'b1, 1'b0);
    check_val("drain_empty", word_valid, 0);
    check_val("drain_empty_data", word_data, 0);
    clk_bit(1'b1, 1'b0);
    check_val("underflow_fill", fill_level, 0);

    // ---- partial word: 12 bits then CS high ----
    word_ready = 1'b0;
    for (int i = 0; i < 12; i++) clk_bit(1'b0, 1'b1);
    check_val("partial_pre_pdrop", partial_drop, 0);
    clk_bit(1'b1, 1'b0);
    check_val("partial_pulse", partial_drop, 1);
    check_val("partial_nopush", word_valid, 0);
    check_val("partial_pclk", pixel_clock, 1);
    clk_bit(1'b1, 1'b0);
    check_val("partial_pulse_end", partial_drop, 0);
    send_word(32'h12345678);
    check_val("after_partial_data", word_data, 32'h12345678);
    check_val("after_partial_fill", fill_level, 1);
    word_ready = 1'b1;
    clk_bit(1'b1, 1'b0);
    word_ready = 1'b0;
    check_val("after_partial_pop", fill_level, 0);

    // ---- 16-bit LSB-first instance ----
    v16 = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      cs16_n = 1'b0; mosi16 = v16[i];
      step();
      if (i == 6) check_val("w16_pclk_bc7", pclk16, 1);
      if (i == 7) check_val("w16_pclk_bc8", pclk16, 0);
    end
    check_val("w16_valid", valid16, 1);
    check_val("w16_data_0001", data16, 16'h0001);
    v16 = 16'hC3A5;
    for (int i = 0; i < 16; i++) begin
      cs16_n = 1'b0; mosi16 = v16[i];
      step();
    end
    check_val("w16_fill2", fill16, 2);
    cs16_n = 1'b1; ready16 = 1'b1;
    step();
    check_val("w16_data_c3a5", data16, 16'hC3A5);
    check_val("w16_main_untouched", fill_level, 0);

    // ---- reset mid-word with two words buffered ----
    send_word(32'hAAAA5555);
    send_word(32'h0F0F0F0F);
    for (int i = 0; i < 20; i++) clk_bit(1'b0, 1'b1);
    check_val("prerst_fill", fill_level, 2);
    check_val("prerst_ovf", overflow, 1);
    check_val("prerst_pclk", pixel_clock, 0);
    reset = 1'b1;
    clk_bit(1'b0, 1'b1);
    check_val("midrst_valid", word_valid, 0);
    check_val("midrst_data", word_data, 0);
    check_val("midrst_fill", fill_level, 0);
    check_val("midrst_ovf", overflow, 0);
    check_val("midrst_pdrop", partial_drop, 0);
    check_val("midrst_pclk", pixel_clock, 1);
    reset = 1'b0;
    send_word(32'h0F0F1234);
    check_val("postrst_data", word_data, 32'h0F0F1234);
    check_val("postrst_fill", fill_level, 1);
    check_val("postrst_ovf", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
